// File: rtl/alu_share_arb_pkg.sv
// rtl/alu_share_arb_pkg.sv - shared constants and state encoding for alu_share_arb
package alu_share_arb_pkg;

    localparam int DEF_BITS = 4;
    localparam int DEF_OPW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// rtl/alu_share_arb_rr_arb2.sv - 2-way round-robin grant, combinational
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    // A lone requester wins outright; on a tie the preferred client wins.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-client round-robin controller sharing one external ALU
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int BITS = DEF_BITS,
    parameter int OPW  = DEF_OPW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [BITS-1:0] req0_a,
    input  logic [BITS-1:0] req0_b,
    input  logic [OPW-1:0]  req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [BITS-1:0] req1_a,
    input  logic [BITS-1:0] req1_b,
    input  logic [OPW-1:0]  req1_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [BITS-1:0] rsp0_data,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [BITS-1:0] rsp1_data,
    output logic [BITS-1:0] alu_a,
    output logic [BITS-1:0] alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [BITS-1:0] alu_r,
    output logic            busy
);

    state_t          state;
    state_t          next_state;
    logic            prio;
    logic            owner;
    logic [1:0]      grant;
    logic            accept;
    logic            rsp_done;
    logic [BITS-1:0] a_q;
    logic [BITS-1:0] b_q;
    logic [OPW-1:0]  op_q;
    logic [BITS-1:0] result_q;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .prio  (prio),
        .grant (grant)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: accept a granted request, spend one cycle executing, then wait for the owner to take the result.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    accept     = 1'b1;
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: next_state = ST_RESP;
            ST_RESP: begin
                if (owner ? rsp1_ready : rsp0_ready) begin
                    rsp_done   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Operand capture, result capture and fairness bookkeeping; the last served client loses the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            owner    <= 1'b0;
            prio     <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= grant[1] ? req1_a  : req0_a;
                b_q   <= grant[1] ? req1_b  : req0_b;
                op_q  <= grant[1] ? req1_op : req0_op;
                owner <= grant[1];
            end
            if (state == ST_EXEC) begin
                result_q <= alu_r;
            end
            if (rsp_done) begin
                prio <= ~owner;
            end
        end
    end

    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];
    assign rsp0_valid = (state == ST_RESP) && !owner;
    assign rsp1_valid = (state == ST_RESP) && owner;
    assign rsp0_data  = result_q;
    assign rsp1_data  = result_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb with an adder stub ALU
module tb_alu_share_arb;

    localparam int BITS = 4;
    localparam int OPW  = 3;

    logic            clk;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [BITS-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]  req0_op, req1_op;
    logic            rsp0_valid, rsp1_valid;
    logic            rsp0_ready, rsp1_ready;
    logic [BITS-1:0] rsp0_data, rsp1_data;
    logic [BITS-1:0] alu_a, alu_b, alu_r;
    logic [OPW-1:0]  alu_op;
    logic            busy;

    int vectors;
    int miscompares;
    int cyc;

    // Model: idle (m_age<0), or number of cycles since the accepting edge.
    int m_age;
    int m_owner;
    int m_last;
    int m_a, m_b, m_op;
    int chosen;
    int exp_res;
    bit chk_en;

    int log_owner[$];
    int log_data[$];
    int log_cyc[$];

    alu_share_arb #(.BITS(BITS), .OPW(OPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_r      (alu_r),
        .busy       (busy)
    );

    assign alu_r = alu_a + alu_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every-cycle comparison against the model, then advance the model by one clock.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req0_ready", int'(req0_ready), 0);
            chk("rst_req1_ready", int'(req1_ready), 0);
            chk("rst_rsp0_valid", int'(rsp0_valid), 0);
            chk("rst_rsp1_valid", int'(rsp1_valid), 0);
            chk("rst_rsp0_data", int'(rsp0_data), 0);
            chk("rst_rsp1_data", int'(rsp1_data), 0);
            chk("rst_alu_a", int'(alu_a), 0);
            chk("rst_alu_b", int'(alu_b), 0);
            chk("rst_alu_op", int'(alu_op), 0);
            chk("rst_busy", int'(busy), 0);
            m_age = -1; m_owner = 0; m_last = 1;
            m_a = 0; m_b = 0; m_op = 0;
        end else if (chk_en) begin
            chosen = -1;
            if (m_age < 0) begin
                if (req0_valid && req1_valid) chosen = (m_last == 0) ? 1 : 0;
                else if (req0_valid) chosen = 0;
                else if (req1_valid) chosen = 1;
            end
            exp_res = (m_a + m_b) % (1 << BITS);
            chk("req0_ready", int'(req0_ready), int'(chosen == 0));
            chk("req1_ready", int'(req1_ready), int'(chosen == 1));
            chk("rsp0_valid", int'(rsp0_valid), int'(m_age >= 1 && m_owner == 0));
            chk("rsp1_valid", int'(rsp1_valid), int'(m_age >= 1 && m_owner == 1));
            chk("busy", int'(busy), int'(m_age >= 0));
            chk("alu_a", int'(alu_a), m_a);
            chk("alu_b", int'(alu_b), m_b);
            chk("alu_op", int'(alu_op), m_op);
            if (m_age >= 1 && m_owner == 0) chk("rsp0_data", int'(rsp0_data), exp_res);
            if (m_age >= 1 && m_owner == 1) chk("rsp1_data", int'(rsp1_data), exp_res);

            if (chosen >= 0) begin
                m_owner = chosen;
                m_a  = (chosen == 1) ? int'(req1_a)  : int'(req0_a);
                m_b  = (chosen == 1) ? int'(req1_b)  : int'(req0_b);
                m_op = (chosen == 1) ? int'(req1_op) : int'(req0_op);
                m_age = 0;
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (m_age >= 1) begin
                if ((m_owner == 0) ? rsp0_ready : rsp1_ready) begin
                    log_owner.push_back(m_owner);
                    log_data.push_back(exp_res);
                    log_cyc.push_back(cyc);
                    m_last = m_owner;
                    m_age = -1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Wait (bounded) for client n's handshake, then drop its valid after the accepting edge.
    task automatic wait_accept(input int n);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (n == 0 && req0_valid && req0_ready) seen = 1'b1;
            if (n == 1 && req1_valid && req1_ready) seen = 1'b1;
        end
        chk("accept_timeout", int'(seen), 1);
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; chk_en = 1'b1;
        m_age = -1; m_owner = 0; m_last = 1; m_a = 0; m_b = 0; m_op = 0;
        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        do_reset();

        // 1: single request, fixed latency.
        @(posedge clk); #1;
        req0_a = 3; req0_b = 2; req0_op = 1; req0_valid = 1'b1;
        @(negedge clk);
        chk("t1_ready", int'(req0_ready), 1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_alu_a", int'(alu_a), 3);
        chk("t1_alu_b", int'(alu_b), 2);
        chk("t1_alu_op", int'(alu_op), 1);
        chk("t1_busy", int'(busy), 1);
        @(negedge clk);
        chk("t1_rsp0_valid", int'(rsp0_valid), 1);
        chk("t1_rsp0_data", int'(rsp0_data), 5);
        chk("t1_rsp1_valid", int'(rsp1_valid), 0);
        repeat (3) @(posedge clk);

        // 2: simultaneous requests after reset, client 0 first, wrap-around on client 1.
        do_reset();
        log_owner.delete(); log_data.delete(); log_cyc.delete();
        req0_a = 1; req0_b = 1; req0_op = 0;
        req1_a = 7; req1_b = 9; req1_op = 2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_accept(0);
        wait_accept(1);
        repeat (4) @(posedge clk);
        chk("t2_count", log_owner.size(), 2);
        if (log_owner.size() == 2) begin
            chk("t2_first_owner", log_owner[0], 0);
            chk("t2_first_data", log_data[0], 2);
            chk("t2_second_owner", log_owner[1], 1);
            chk("t2_second_data", log_data[1], 0);
        end

        // 3: backpressure on client 1 while client 0 waits.
        #1;
        rsp1_ready = 1'b0;
        req1_a = 4; req1_b = 4; req1_op = 0; req1_valid = 1'b1;
        wait_accept(1);
        req0_a = 6; req0_b = 1; req0_op = 3; req0_valid = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (rsp1_valid) seen = 1'b1;
            end
            chk("t3_rsp_timeout", int'(seen), 1);
        end
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", int'(rsp1_valid), 1);
            chk("t3_hold_data", int'(rsp1_data), 8);
            chk("t3_req0_blocked", int'(req0_ready), 0);
            chk("t3_busy", int'(busy), 1);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1 rsp1_ready = 1'b1;
        wait_accept(0);
        repeat (4) @(posedge clk);

        // 4: fairness with both clients continuously valid.
        do_reset();
        log_owner.delete(); log_data.delete(); log_cyc.delete();
        req0_a = 1; req0_b = 2; req0_op = 0;
        req1_a = 3; req1_b = 4; req1_op = 1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 40 && log_owner.size() < 6; k++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t4_count", log_owner.size(), 6);
        for (int i = 0; i < 6 && i < log_owner.size(); i++) begin
            chk("t4_owner", log_owner[i], i % 2);
            chk("t4_data", log_data[i], (i % 2 == 0) ? 3 : 7);
            if (i > 0) chk("t4_spacing", log_cyc[i] - log_cyc[i-1], 3);
        end
        repeat (3) @(posedge clk);

        // 5: reset during EXEC discards the transaction immediately.
        #1;
        req0_a = 5; req0_b = 6; req0_op = 4; req0_valid = 1'b1;
        @(negedge clk);
        chk("t5_ready", int'(req0_ready), 1);
        @(posedge clk); #1;
        chk("t5_exec_busy", int'(busy), 1);
        rst = 1'b1; req0_valid = 1'b0;
        #1;
        chk("t5_alu_a", int'(alu_a), 0);
        chk("t5_alu_b", int'(alu_b), 0);
        chk("t5_alu_op", int'(alu_op), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_rsp0_valid", int'(rsp0_valid), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req0_a = 1; req0_b = 0; req1_a = 0; req1_b = 1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("t5_prio_req0", int'(req0_ready), 1);
        chk("t5_prio_req1", int'(req1_ready), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_accept(1);
        repeat (4) @(posedge clk);

        // 6: operands held through a long idle stretch.
        #1;
        req0_a = 2; req0_b = 3; req0_op = 0; req0_valid = 1'b1;
        wait_accept(0);
        repeat (3) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t6_alu_a", int'(alu_a), 2);
            chk("t6_alu_b", int'(alu_b), 3);
            chk("t6_rsp0_valid", int'(rsp0_valid), 0);
            chk("t6_rsp1_valid", int'(rsp1_valid), 0);
            chk("t6_req0_ready", int'(req0_ready), 0);
            chk("t6_req1_ready", int'(req1_ready), 0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
